// File: rtl/dram_arbiter_pkg.sv
// Shared types and default widths for the DRAM arbiter slice.
package Usertype_BEV;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arbState_e;

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester and bridge handshake bundle for the DRAM arbiter.
// slave: arbiter side; master: requesters/bridge environment side.
interface dram_arbiter_if #(
    parameter int ADDR_W = Usertype_BEV::ADDR_W,
    parameter int DATA_W = Usertype_BEV::DATA_W
);

    logic [1:0]             req_valid;
    logic [1:0]             req_r_wb;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_data_w;
    logic [1:0]             req_ready;
    logic [1:0]             resp_valid;
    logic [DATA_W-1:0]      resp_data_r;

    logic                   C_in_valid;
    logic                   C_r_wb;
    logic [ADDR_W-1:0]      C_addr;
    logic [DATA_W-1:0]      C_data_w;
    logic                   C_out_valid;
    logic [DATA_W-1:0]      C_data_r;

    modport slave (
        input  req_valid, req_r_wb, req_addr, req_data_w, C_out_valid, C_data_r,
        output req_ready, resp_valid, resp_data_r, C_in_valid, C_r_wb, C_addr, C_data_w
    );

    modport master (
        output req_valid, req_r_wb, req_addr, req_data_w, C_out_valid, C_data_r,
        input  req_ready, resp_valid, resp_data_r, C_in_valid, C_r_wb, C_addr, C_data_w
    );

endinterface

// File: rtl/dram_arbiter_rr.sv
// Two-way round-robin grant selection (purely combinational).
module dram_arb_rr (
    input  logic [1:0] pend,
    input  logic       lastGrant,
    output logic       grantValid,
    output logic       grantIdx
);

    // Lone pender wins; with both pending, the one not served last wins.
    always_comb begin
        grantValid = |pend;
        grantIdx   = 1'b0;
        case (pend)
            2'b10:   grantIdx = 1'b1;
            2'b11:   grantIdx = ~lastGrant;
            default: grantIdx = 1'b0;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-requester DRAM arbiter: one pending slot per requester, a single
// outstanding command to the bridge, round-robin between requesters.
module dram_arbiter #(
    parameter int ADDR_W = Usertype_BEV::ADDR_W,
    parameter int DATA_W = Usertype_BEV::DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    dram_arbiter_if.slave bus
);

    import Usertype_BEV::*;

    arbState_e         state;
    logic [1:0]        pend;
    logic [1:0]        accept;
    logic [1:0]        pendClr;
    logic              lastGrant;
    logic              curGrant;
    logic              grantValid;
    logic              grantIdx;

    logic [1:0]        slotRwb;
    logic [ADDR_W-1:0] slotAddr [2];
    logic [DATA_W-1:0] slotData [2];

    // A request is only taken into a free slot; pulses into a busy slot vanish.
    assign accept        = bus.req_valid & ~pend;
    assign bus.req_ready = ~pend;
    assign pendClr       = (state == ARB_WAIT && bus.C_out_valid) ? (2'b01 << curGrant) : 2'b00;

    dram_arb_rr uRr (
        .pend       (pend),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    // Capture request fields into the per-requester slot on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotRwb  <= '0;
            slotAddr <= '{default: '0};
            slotData <= '{default: '0};
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    slotRwb[i]  <= bus.req_r_wb[i];
                    slotAddr[i] <= bus.req_addr[i];
                    slotData[i] <= bus.req_data_w[i];
                end
            end
        end
    end

    // Arbitration FSM with registered bridge command and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            pend            <= '0;
            lastGrant       <= 1'b1;
            curGrant        <= 1'b0;
            bus.C_in_valid  <= 1'b0;
            bus.C_r_wb      <= 1'b0;
            bus.C_addr      <= '0;
            bus.C_data_w    <= '0;
            bus.resp_valid  <= '0;
            bus.resp_data_r <= '0;
        end else begin
            // accept only touches free slots and pendClr only a busy one
            pend           <= (pend | accept) & ~pendClr;
            bus.C_in_valid <= 1'b0;
            bus.resp_valid <= '0;
            case (state)
                ARB_IDLE: begin
                    if (grantValid) begin
                        curGrant     <= grantIdx;
                        bus.C_r_wb   <= slotRwb[grantIdx];
                        bus.C_addr   <= slotAddr[grantIdx];
                        bus.C_data_w <= slotData[grantIdx];
                        state        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    bus.C_in_valid <= 1'b1;
                    state          <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (bus.C_out_valid) begin
                        bus.resp_valid  <= 2'b01 << curGrant;
                        bus.resp_data_r <= bus.C_data_r;
                        lastGrant       <= curGrant;
                        state           <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, DRAM box-index width.
REQ-002 SHALL have parameter DATA_W, default 64, DRAM word width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester one-cycle request pulse (index 0/1).
REQ-006 SHALL have port req_r_wb  in  2  per-requester 1=read, 0=write.
REQ-007 SHALL have port req_addr  in  2xADDR_W  per-requester address.
REQ-008 SHALL have port req_data_w  in  2xDATA_W  per-requester write data.
REQ-009 SHALL have port req_ready  out  2  per-requester slot-free flag.
REQ-010 SHALL have port resp_valid  out  2  per-requester one-cycle completion pulse.
REQ-011 SHALL have port resp_data_r  out  DATA_W  read data, shared, qualified by resp_valid.
REQ-012 SHALL have port C_in_valid  out  1  one-cycle command pulse to bridge.
REQ-013 SHALL have ports C_r_wb/C_addr/C_data_w  out  1/ADDR_W/DATA_W  command fields, held stable from C_in_valid until C_out_valid.
REQ-014 SHALL have port C_out_valid  in  1  bridge completion pulse (reads and writes).
REQ-015 SHALL have port C_data_r  in  DATA_W  bridge read data, valid with C_out_valid.

Function
REQ-016 SHALL hold one pending slot per requester; req_valid with req_ready=1 latches r_wb/addr/data and sets pend[i] at that edge.
REQ-017 SHALL drive req_ready[i] = ~pend[i]; req_valid while req_ready=0 SHALL be ignored with no state change.
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, all outputs registered.
REQ-019 IDLE: if any pend, select grant g, load C_* fields from slot g, go ISSUE; else stay.
REQ-020 ISSUE: C_in_valid=1 for exactly this one cycle; go WAIT.
REQ-021 WAIT: on C_out_valid, resp_valid[g]=1 for one cycle next cycle, resp_data_r=C_data_r (writes: C_data_r passed unchanged), clear pend[g], last_grant<=g, go IDLE.
REQ-022 Grant: single pender wins; both pending -> requester != last_grant (round-robin).
REQ-023 Latency: req_valid at edge E0 with arbiter idle -> C_in_valid high in cycle after edge E2; resp_valid high one cycle after the C_out_valid cycle.
REQ-024 A request latched while another is in service SHALL be held and served next; new req_valid on the granted port is refused until pend clears (req_ready rises the cycle resp_valid rises).
REQ-025 C_out_valid in IDLE or ISSUE SHALL be ignored.
REQ-026 resp_data_r SHALL hold its last value between responses; resp_valid never asserted on both bits.
REQ-027 Simultaneous req_valid on both ports at one edge SHALL latch both.

Reset
REQ-028 rst_n low SHALL asynchronously clear pend, FSM=IDLE, last_grant=1 (port 0 first), and all outputs to 0 except req_ready=2'b11.
REQ-029 Reset mid-transaction SHALL drop pending and in-flight requests without any resp_valid; late C_out_valid after reset SHALL be ignored.

Structure
REQ-030 Shared package Usertype_BEV SHALL hold the FSM state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT) and ADDR_W/DATA_W constants.
REQ-031 Grant selection SHALL be a sub-module dram_arb_rr (pend[1:0], last_grant -> grant valid, index), combinational.

Verification
REQ-032 Port0 read addr 8'h05, bridge returns 64'hA5A5 after 3 cycles -> one C_in_valid with C_addr=5, C_r_wb=1, then resp_valid=2'b01, resp_data_r=64'hA5A5.
REQ-033 Both ports request at the same edge after reset -> port0 served first, then port1; grant order 0,1,0,1 over four repeated pairs.
REQ-034 Port1 write addr 8'hFF data 64'h1234 while port0 in WAIT -> port1 C_in_valid only after port0 resp_valid, fields 8'hFF/64'h1234/r_wb=0.
REQ-035 Port0 re-pulses req_valid while pend[0]=1 -> ignored; exactly one C_in_valid issued.
REQ-036 rst_n low during WAIT, then spurious C_out_valid -> no resp_valid, req_ready=2'b11, outputs 0.
REQ-037 C_out_valid pulsed in IDLE -> no resp_valid, no state change.
